// File: rtl/y_mux_pkg.sv
// Shared select encodings and default widths for the Y-mux slice.
package y_mux_pkg;

    localparam int DW_DEF = 48;
    localparam int MW_DEF = 43;

    typedef enum logic [1:0] {
        Y_ZERO = 2'b00,
        Y_M    = 2'b01,
        Y_ONES = 2'b10,
        Y_C    = 2'b11
    } y_sel_e;

    localparam logic [1:0] X_M = 2'b01;

endpackage

// File: rtl/y_mux_sel.sv
// Combinational Y-mux: data select, sign extension of M, and opmode legality check.
module y_mux_sel
    import y_mux_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int MW = MW_DEF
) (
    input  logic [DW-1:0] in0,
    input  logic [MW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [1:0]    sel1,
    input  logic [1:0]    sel2,
    output logic [DW-1:0] y_d,
    output logic          err_d
);

    logic   x_is_m;
    y_sel_e y_sel;

    always_comb begin
        y_sel  = y_sel_e'(sel2);
        x_is_m = (sel1 == X_M);
        y_d    = '0;
        err_d  = 1'b0;
        unique case (y_sel)
            Y_ZERO: y_d = in0;
            Y_M: begin
                // M is only meaningful when split across X and Y; otherwise force zero.
                if (x_is_m) begin
                    y_d = {{(DW-MW){in1[MW-1]}}, in1};
                end else begin
                    err_d = 1'b1;
                end
            end
            Y_ONES: y_d = in2;
            Y_C:    y_d = in3;
            default: y_d = '0;
        endcase
        if (x_is_m && (y_sel != Y_M)) begin
            err_d = 1'b1;
        end
    end

endmodule

// File: rtl/y_mux.sv
// Registered Y-mux: wraps y_mux_sel with a clock-enabled output register.
module y_mux
    import y_mux_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int MW = MW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [DW-1:0] in0,
    input  logic [MW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [1:0]    sel1,
    input  logic [1:0]    sel2,
    output logic [DW-1:0] out,
    output logic          opmode_err
);

    logic [DW-1:0] y_d;
    logic          err_d;
    logic [DW-1:0] out_d, out_q;
    logic          opmode_err_d, opmode_err_q;

    y_mux_sel #(
        .DW(DW),
        .MW(MW)
    ) u_sel (
        .in0  (in0),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .sel1 (sel1),
        .sel2 (sel2),
        .y_d  (y_d),
        .err_d(err_d)
    );

    always_comb begin
        out_d        = out_q;
        opmode_err_d = opmode_err_q;
        if (ce) begin
            out_d        = y_d;
            opmode_err_d = err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            opmode_err_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            opmode_err_q <= opmode_err_d;
        end
    end

    assign out        = out_q;
    assign opmode_err = opmode_err_q;

endmodule

// File: tb/tb_y_mux.sv
// Self-checking bench for y_mux: directed scenarios plus randomized scoreboard run.
module tb_y_mux;

    localparam int DW = 48;
    localparam int MW = 43;

    logic          clk = 1'b0;
    logic          rst, ce;
    logic [DW-1:0] in0, in2, in3;
    logic [MW-1:0] in1;
    logic [1:0]    sel1, sel2;
    logic [DW-1:0] out;
    logic          opmode_err;

    int checks = 0;
    int errors = 0;

    y_mux #(.DW(DW), .MW(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .sel1      (sel1),
        .sel2      (sel2),
        .out       (out),
        .opmode_err(opmode_err)
    );

    always #5 clk = ~clk;

    // Reference: M interpreted as a signed integer, then wrapped to DW bits.
    function automatic logic [DW-1:0] ref_y(input logic [DW-1:0] a0, input logic [MW-1:0] m,
                                            input logic [DW-1:0] a2, input logic [DW-1:0] a3,
                                            input logic [1:0] s1, input logic [1:0] s2);
        longint v;
        logic [63:0] w;
        case (s2)
            2'd0: return a0;
            2'd1: begin
                if (s1 != 2'd1) return '0;
                v = longint'(m);
                if (v >= (longint'(1) << (MW - 1))) v = v - (longint'(1) << MW);
                w = 64'(v);
                return w[DW-1:0];
            end
            2'd2: return a2;
            default: return a3;
        endcase
    endfunction

    function automatic logic ref_err(input logic [1:0] s1, input logic [1:0] s2);
        return (s1 == 2'd1) != (s2 == 2'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1;
        in0 = '0; in1 = '1; in2 = '1; in3 = 48'h1234_5678_9ABC;
        sel1 = 2'b00; sel2 = 2'b11;
        tick();
        checks++;
        if (out !== '0 || opmode_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: out=%h err=%b expected out=0 err=0", out, opmode_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_sign_ext();
        ce = 1'b1; sel1 = 2'b01; sel2 = 2'b01; in1 = 43'h400_0000_0001;
        tick();
        checks++;
        if (out !== 48'hFC00_0000_0001 || opmode_err !== 1'b0) begin
            errors++;
            $display("FAIL sign_ext_neg: out=%h err=%b expected out=fc0000000001 err=0", out, opmode_err);
        end
        in1 = 43'h3FF_FFFF_FFFF;
        tick();
        checks++;
        if (out !== 48'h03FF_FFFF_FFFF || opmode_err !== 1'b0) begin
            errors++;
            $display("FAIL sign_ext_pos: out=%h err=%b expected out=03ffffffffff err=0", out, opmode_err);
        end
    endtask

    task automatic test_select();
        ce = 1'b1; sel1 = 2'b00;
        in0 = '0; in2 = 48'hFFFF_FFFF_FFFF; in3 = 48'h1234_5678_9ABC; in1 = 43'h5A5;
        sel2 = 2'b11;
        tick();
        checks++;
        if (out !== 48'h1234_5678_9ABC || opmode_err !== 1'b0) begin
            errors++;
            $display("FAIL sel_c: out=%h err=%b expected out=123456789abc err=0", out, opmode_err);
        end
        sel2 = 2'b10;
        tick();
        checks++;
        if (out !== 48'hFFFF_FFFF_FFFF || opmode_err !== 1'b0) begin
            errors++;
            $display("FAIL sel_ones: out=%h err=%b expected out=ffffffffffff err=0", out, opmode_err);
        end
        sel2 = 2'b00;
        tick();
        checks++;
        if (out !== '0 || opmode_err !== 1'b0) begin
            errors++;
            $display("FAIL sel_zero: out=%h err=%b expected out=0 err=0", out, opmode_err);
        end
    endtask

    task automatic test_illegal();
        ce = 1'b1; in3 = 48'hBEEF_CAFE_0123;
        sel1 = 2'b00; sel2 = 2'b01; in1 = 43'h1;
        tick();
        checks++;
        if (out !== '0 || opmode_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_m: out=%h err=%b expected out=0 err=1", out, opmode_err);
        end
        sel1 = 2'b01; sel2 = 2'b11;
        tick();
        checks++;
        if (out !== 48'hBEEF_CAFE_0123 || opmode_err !== 1'b1) begin
            errors++;
            $display("FAIL x_m_no_y_m: out=%h err=%b expected out=beefcafe0123 err=1", out, opmode_err);
        end
    endtask

    task automatic test_ce_hold();
        ce = 1'b1; sel1 = 2'b00; sel2 = 2'b11; in3 = 48'h5;
        tick();
        checks++;
        if (out !== 48'h5) begin
            errors++;
            $display("FAIL ce_load: out=%h expected 5", out);
        end
        ce = 1'b0; in3 = 48'hA; sel1 = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out !== 48'h5 || opmode_err !== 1'b0) begin
                errors++;
                $display("FAIL ce_hold[%0d]: out=%h err=%b expected out=5 err=0", i, out, opmode_err);
            end
        end
        // Reset overrides ce=0
        rst = 1'b1;
        tick();
        checks++;
        if (out !== '0) begin
            errors++;
            $display("FAIL rst_over_ce: out=%h expected 0", out);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        ce = 1'b1; sel1 = 2'b00; sel2 = 2'b11; in3 = 48'h7777_0000_1111;
        rst = 1'b1;
        tick();
        checks++;
        if (out !== '0 || opmode_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: out=%h err=%b expected out=0 err=0", out, opmode_err);
        end
        rst = 1'b0; in3 = 48'h0000_2222_3333;
        tick();
        checks++;
        if (out !== 48'h0000_2222_3333) begin
            errors++;
            $display("FAIL rst_release: out=%h expected 000022223333", out);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_out;
        logic          exp_err;
        logic [63:0]   r;
        exp_out = out;
        exp_err = opmode_err;
        for (int n = 0; n < 2500; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            ce  = ($urandom_range(0, 3) != 0);
            r = {$urandom(), $urandom()}; in0 = r[DW-1:0];
            r = {$urandom(), $urandom()}; in1 = r[MW-1:0];
            r = {$urandom(), $urandom()}; in2 = r[DW-1:0];
            r = {$urandom(), $urandom()}; in3 = r[DW-1:0];
            sel1 = 2'($urandom_range(0, 3));
            sel2 = 2'($urandom_range(0, 3));
            if (n < 400)       sel1 = 2'b01;
            else if (n < 800)  sel1 = 2'b00;
            else if (n < 1200) sel2 = 2'b01;
            else if (n < 1600) sel2 = 2'b00;
            if (rst) begin
                exp_out = '0;
                exp_err = 1'b0;
            end else if (ce) begin
                exp_out = ref_y(in0, in1, in2, in3, sel1, sel2);
                exp_err = ref_err(sel1, sel2);
            end
            tick();
            checks++;
            if (out !== exp_out || opmode_err !== exp_err) begin
                errors++;
                $display("FAIL random[%0d] s1=%b s2=%b: out=%h err=%b expected out=%h err=%b",
                         n, sel1, sel2, out, opmode_err, exp_out, exp_err);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0; sel1 = '0; sel2 = '0;
        test_reset();
        test_sign_ext();
        test_select();
        test_illegal();
        test_ce_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/y_mux.md
Y_MUX -- requirements
Module: y_mux

Interface
REQ-001 Parameter: DW, 48, data width of in0/in2/in3/out.
REQ-002 Parameter: MW, 43, width of multiplier input in1 (MW SHALL be < DW).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: ce  input  1  output-register clock enable.
REQ-006 Port: in0  input  DW  zero-source input (normally tied 0).
REQ-007 Port: in1  input  MW  multiplier result M (two's complement).
REQ-008 Port: in2  input  DW  all-ones-source input (normally 48'hFFFF_FFFF_FFFF).
REQ-009 Port: in3  input  DW  C / concatenated operand input.
REQ-010 Port: sel1  input  2  X-mux select (OPMODE[1:0]).
REQ-011 Port: sel2  input  2  Y-mux select (OPMODE[3:2]).
REQ-012 Port: out  output  DW  registered Y-mux result.
REQ-013 Port: opmode_err  output  1  registered flag, illegal sel1/sel2 pairing.
REQ-014 One clock; reset is synchronous and active-high (clk, rst).

Function
REQ-015 Next value of out SHALL be selected by sel2: 00 -> in0; 01 -> in1 sign-extended from MW to DW bits; 10 -> in2; 11 -> in3.
REQ-016 sel2=01 is legal only with sel1=01 (M split across X and Y); sel2=01 with sel1!=01 SHALL load out=0 and opmode_err=1.
REQ-017 sel1=01 with sel2!=01 SHALL also set opmode_err=1; out still follows REQ-015.
REQ-018 All other combinations SHALL set opmode_err=0.
REQ-019 Latency exactly 1 clk: out/opmode_err update on the rising edge when ce=1; hold when ce=0.
REQ-020 sel1 affects only legality checks, never the selected data value.
REQ-021 Sign extension: out[DW-1:MW] = in1[MW-1] for every sel2=01 legal load.
REQ-022 No X propagation from unselected inputs; unselected inputs SHALL not affect out.

Reset
REQ-023 rst=1 at a rising edge SHALL clear out to 0 and opmode_err to 0, overriding ce.
REQ-024 Reset asserted mid-operation discards the pending selection; first load after deassertion uses inputs present at that edge.

Structure
REQ-025 Shared package holds select encodings (Y_ZERO=00, Y_M=01, Y_ONES=10, Y_C=11, X_M=01) and DW/MW defaults.
REQ-026 One sub-module natural: y_mux_sel (combinational select, sign extension, legality check); y_mux wraps it with the output register.

Verification
REQ-027 rst=1 one cycle, ce=1 -> out=0, opmode_err=0 after edge.
REQ-028 ce=1, sel1=01, sel2=01, in1=43'h400_0000_0001 -> after 1 clk out=48'hFC00_0000_0001... sign bit extended (out[47:43]=5'h1F), opmode_err=0.
REQ-029 ce=1, sel1=00, sel2=11, in3=48'h1234_5678_9ABC -> out=48'h1234_5678_9ABC; sel2=10, in2=48'hFFFF_FFFF_FFFF -> out=all ones; sel2=00, in0=0 -> out=0.
REQ-030 ce=1, sel1=00, sel2=01, in1=43'h1 -> out=0, opmode_err=1; then sel1=01, sel2=11 -> out=in3, opmode_err=1.
REQ-031 Load out=48'h5, then ce=0 with sel2=11, in3=48'hA for 3 clks -> out stays 48'h5.
REQ-032 Randomized 2500 cycles over all sel1/sel2 with scoreboard model of REQ-015..018, including fixed sel1=01/00 and sel2=01/00 sweeps.
